// File: rtl/layer_sched_pkg.sv
// Layer scheduler shared types: engine ops, descriptor layout, bank bases
// and the fixed per-image descriptor table.
package layer_sched_pkg;

  typedef enum logic [1:0] {
    CONV, MAXP, DENSE, RES
  } op_e;

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT, GAP, FINISH
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] matrix;
    logic [4:0] mem;
    logic [4:0] filt;
    logic       src;
    logic       glob;
    logic [4:0] passes;
  } desc_t;

  localparam int BANK_A = 0;
  localparam int BANK_B = 3136;

  // src=0 reads bank A and writes bank B; layers ping-pong between banks
  function automatic desc_t desc_at(input logic [3:0] idx);
    desc_t d;
    unique case (idx)
      4'd0:    d = '{CONV,  5'd28, 5'd1,  5'd4,  1'b0, 1'b0, 5'd4};
      4'd1:    d = '{CONV,  5'd28, 5'd4,  5'd4,  1'b1, 1'b0, 5'd4};
      4'd2:    d = '{MAXP,  5'd28, 5'd4,  5'd4,  1'b0, 1'b0, 5'd4};
      4'd3:    d = '{CONV,  5'd14, 5'd4,  5'd8,  1'b1, 1'b0, 5'd8};
      4'd4:    d = '{CONV,  5'd14, 5'd8,  5'd8,  1'b0, 1'b0, 5'd8};
      4'd5:    d = '{MAXP,  5'd14, 5'd8,  5'd8,  1'b1, 1'b0, 5'd8};
      4'd6:    d = '{CONV,  5'd7,  5'd8,  5'd16, 1'b0, 1'b0, 5'd16};
      4'd7:    d = '{CONV,  5'd7,  5'd16, 5'd16, 1'b1, 1'b1, 5'd16};
      4'd8:    d = '{DENSE, 5'd1,  5'd16, 5'd11, 1'b0, 1'b0, 5'd1};
      default: d = '{RES,   5'd1,  5'd11, 5'd11, 1'b1, 1'b0, 5'd1};
    endcase
    return d;
  endfunction

  function automatic op_e op_at(input logic [3:0] idx);
    desc_t d;
    d = desc_at(idx);
    return d.op;
  endfunction

  function automatic logic [4:0] passes_at(input logic [3:0] idx);
    desc_t d;
    d = desc_at(idx);
    return d.passes;
  endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Scheduler <-> engines/host bundle: start/load/done inputs,
// engine enables, pass configuration and status.
interface layer_sched_if #(
  parameter int AW = 13
);
  logic          go;
  logic          load_done;
  logic          conv_done;
  logic          maxp_done;
  logic          dense_done;
  logic          res_done;
  logic          conv_en;
  logic          maxp_en;
  logic          dense_en;
  logic          result_en;
  logic [AW-1:0] memstartp;
  logic [AW-1:0] memstartzap;
  logic [4:0]    matrix;
  logic [4:0]    mem;
  logic [4:0]    filt;
  logic          globmaxp_en;
  logic [3:0]    layer;
  logic [4:0]    pass;
  logic          busy;
  logic          stop;
  logic          err;

  modport master (
    input  go, load_done, conv_done, maxp_done, dense_done, res_done,
    output conv_en, maxp_en, dense_en, result_en,
    output memstartp, memstartzap, matrix, mem, filt, globmaxp_en,
    output layer, pass, busy, stop, err
  );

  modport slave (
    output go, load_done, conv_done, maxp_done, dense_done, res_done,
    input  conv_en, maxp_en, dense_en, result_en,
    input  memstartp, memstartzap, matrix, mem, filt, globmaxp_en,
    input  layer, pass, busy, stop, err
  );
endinterface

// File: rtl/layer_sched_wdog.sv
// Engine watchdog: counts WAIT cycles, flags when the count saturates
// to all-ones.
module layer_sched_wdog #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = &cnt;

endmodule

// File: rtl/layer_sched.sv
// Per-image layer sequencer: walks the descriptor table, issues one
// engine pass at a time and aborts on engine timeout.
module layer_sched
  import layer_sched_pkg::*;
#(
  parameter int NUM_LAYERS       = 10,
  parameter int SIZE_address_pix = 13,
  parameter int WDOG_W           = 16
) (
  input logic          clk,
  input logic          rst_n,
  layer_sched_if.master bus
);

  localparam int AW = SIZE_address_pix;

  state_e     state, state_n;
  logic [3:0] layer_n;
  logic [4:0] pass_n;
  op_e        cur_op;
  logic [4:0] cur_passes;
  desc_t      nxt;
  logic       done_hit, expired, start, wait_n;
  int         sq, stride, base_p, base_z;
  logic [AW-1:0] memp_n, memz_n;
  logic       unused_passes;

  assign cur_op        = op_at(bus.layer);
  assign cur_passes    = passes_at(bus.layer);
  assign nxt           = desc_at(layer_n);
  assign unused_passes = ^nxt.passes;
  assign start  = bus.go && (state == IDLE || state == FINISH);
  assign wait_n = (state_n == WAIT);

  always_comb begin
    done_hit = 1'b0;
    unique case (1'b1)
      cur_op == CONV:  done_hit = bus.conv_done;
      cur_op == MAXP:  done_hit = bus.maxp_done;
      cur_op == DENSE: done_hit = bus.dense_done;
      default:         done_hit = bus.res_done;
    endcase
  end

  always_comb begin
    state_n = state;
    layer_n = bus.layer;
    pass_n  = bus.pass;
    unique case (state)
      IDLE, FINISH: if (bus.go) begin
        state_n = LOAD;
        layer_n = '0;
        pass_n  = '0;
      end
      LOAD:  if (bus.load_done) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (done_hit)     state_n = GAP;
        else if (expired) state_n = FINISH;
      end
      GAP: begin
        if (({1'b0, bus.pass} + 6'd1) < {1'b0, cur_passes}) begin
          pass_n  = bus.pass + 5'd1;
          state_n = ISSUE;
        end else if (bus.layer == 4'(NUM_LAYERS - 1)) begin
          pass_n  = '0;
          state_n = FINISH;
        end else begin
          layer_n = bus.layer + 4'd1;
          pass_n  = '0;
          state_n = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bases ping-pong on src; offsets wrap at the picture RAM size
  always_comb begin
    sq = 32'(nxt.matrix) * 32'(nxt.matrix);
    unique case (nxt.op)
      CONV:    stride = sq;
      MAXP:    stride = sq >> 2;
      default: stride = 0;
    endcase
    base_p = nxt.src ? BANK_B : BANK_A;
    base_z = nxt.src ? BANK_A : BANK_B;
    memp_n = AW'(32'(base_p) + 32'(pass_n) * 32'(sq));
    memz_n = AW'(32'(base_z) + 32'(pass_n) * 32'(stride));
  end

  layer_sched_wdog #(.W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ISSUE),
    .en      (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.layer       <= '0;
      bus.pass        <= '0;
      bus.matrix      <= '0;
      bus.mem         <= '0;
      bus.filt        <= '0;
      bus.memstartp   <= '0;
      bus.memstartzap <= '0;
      bus.conv_en     <= 1'b0;
      bus.maxp_en     <= 1'b0;
      bus.dense_en    <= 1'b0;
      bus.result_en   <= 1'b0;
      bus.globmaxp_en <= 1'b0;
      bus.busy        <= 1'b0;
      bus.stop        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      state     <= state_n;
      bus.layer <= layer_n;
      bus.pass  <= pass_n;
      if (state_n == ISSUE) begin
        bus.matrix      <= nxt.matrix;
        bus.mem         <= nxt.mem;
        bus.filt        <= nxt.filt;
        bus.memstartp   <= memp_n;
        bus.memstartzap <= memz_n;
      end
      bus.conv_en     <= wait_n && nxt.op == CONV;
      bus.maxp_en     <= wait_n && nxt.op == MAXP;
      bus.dense_en    <= wait_n && nxt.op == DENSE;
      bus.result_en   <= wait_n && nxt.op == RES;
      bus.globmaxp_en <= wait_n && nxt.op == CONV && nxt.glob;
      bus.busy <= state_n inside {LOAD, ISSUE, WAIT, GAP};
      bus.stop <= state_n == FINISH;
      if (start)
        bus.err <= 1'b0;
      else if (state == WAIT && !done_hit && expired)
        bus.err <= 1'b1;
    end
  end

endmodule
